anton_neopixel_registers_banked: RTL and testbench

- Bus-facing register file and pixel memory for the NeoPixel controller.
- Generalises the two-buffer scheme to BANKS pixel banks. One bank is the display bank, streamed out through a narrow indexed read port. A separate write bank is owned by the bus.
- Bank swaps are tear-free: they are deferred to the frame-sync boundary.
- An internal hardware-sequenced init clears all banks, replacing the external initSlow handshake.

---
 rtl/anton_neopixel_registers_banked.sv | 208 ++++++++++++++++++++
 tb/tb_anton_neopixel_registers_banked.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/anton_neopixel_registers_banked.sv
// Bus register file plus BANKS-deep pixel memory for the NeoPixel controller.
// Bus reads and displayData are registered; bank swaps wait for frame sync or an idle streamer.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 63
`endif
module anton_neopixel_registers_banked #(
  parameter int  BUFFER_END  = `BUFFER_END_DEFAULT,
  parameter int  BANKS       = 2,
  parameter int  ADDR_BITS   = 14,
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1),
  localparam int BANK_BITS   = $clog2(BANKS)
) (
  input  logic                   busClk,
  input  logic                   busResetN,
  input  logic [ADDR_BITS-1:0]   busAddr,
  input  logic [7:0]             busDataIn,
  input  logic                   busWrite,
  input  logic                   busRead,
  output logic [7:0]             busDataOut,
  input  logic                   stream_sync_of,
  input  logic                   syncStart,
  input  logic                   state,
  input  logic [BUFFER_BITS-1:0] displayIndex,
  output logic [7:0]             displayData,
  output logic [12:0]            reg_max,
  output logic                   reg_ctrl_limit,
  output logic                   reg_ctrl_run,
  output logic                   reg_ctrl_loop,
  output logic                   reg_ctrl_32bit,
  output logic [BANK_BITS-1:0]   displayBank,
  output logic [BANK_BITS-1:0]   writeBank,
  output logic                   initBusy,
  output logic                   swapPending
);
  localparam logic [12:0]            MAX_RST   = 13'(BUFFER_END);
  localparam logic [BUFFER_BITS-1:0] LAST_IDX  = BUFFER_BITS'(BUFFER_END);
  localparam logic [BANK_BITS-1:0]   LAST_BANK = BANK_BITS'(BANKS - 1);
  localparam logic [BANK_BITS-1:0]   BANK_ONE  = BANK_BITS'(1);

  typedef enum logic {S_IDLE, S_CLEAR} seq_t;
  seq_t seq_q, seq_d;

  logic [7:0]             mem_q [BANKS][BUFFER_END+1];
  logic [BUFFER_BITS-1:0] clr_cnt_q, clr_cnt_d;
  logic [12:0]            max_q, max_d;
  logic                   limit_q, limit_d, run_q, run_d, loop_q, loop_d, b32_q, b32_d;
  logic [BANK_BITS-1:0]   disp_q, disp_d, wr_q, wr_d;
  logic                   swp_q, swp_d;
  logic [7:0]             dout_q, dout_d, ddata_q, ddata_d;

  logic                   is_reg, reg_wr, buf_ok, didx_ok, buf_we;
  logic [2:0]             reg_idx;
  logic [ADDR_BITS-2:0]   buf_addr;
  logic [BUFFER_BITS-1:0] buf_idx;
  logic [BANK_BITS-1:0]   bank_req, wr_inc;
  logic                   init_busy, init_start, clear_last, swap_apply;

  assign is_reg   = busAddr[ADDR_BITS-1];
  assign reg_idx  = busAddr[2:0];
  assign buf_addr = busAddr[ADDR_BITS-2:0];
  assign buf_idx  = buf_addr[BUFFER_BITS-1:0];
  assign reg_wr   = busWrite && is_reg;
  // Range checks done at 32 bits so they stay meaningful when BUFFER_END+1 is a power of two.
  assign buf_ok   = 32'(buf_addr) <= 32'(BUFFER_END);
  assign didx_ok  = 32'(displayIndex) <= 32'(BUFFER_END);
  assign bank_req = BANK_BITS'(busDataIn % 8'(BANKS));
  assign wr_inc   = (wr_q == LAST_BANK) ? '0 : wr_q + BANK_ONE;

  assign init_start = reg_wr && (reg_idx == 3'd2) && busDataIn[0] && (seq_q == S_IDLE);
  assign clear_last = (seq_q == S_CLEAR) && (clr_cnt_q == LAST_IDX);
  assign swap_apply = !init_busy && swp_q && (stream_sync_of || !run_q) && !init_start;
  assign buf_we     = busWrite && !is_reg && buf_ok && !init_busy;

  always_ff @(posedge busClk or negedge busResetN) begin
    if (!busResetN) seq_q <= S_IDLE;
    else            seq_q <= seq_d;
  end

  always_comb begin
    seq_d = seq_q;
    case (seq_q)
      S_IDLE:  if (init_start) seq_d = S_CLEAR;
      S_CLEAR: if (clear_last) seq_d = S_IDLE;
      default: seq_d = S_IDLE;
    endcase
  end

  always_comb begin
    init_busy = (seq_q == S_CLEAR);
  end

  always_comb begin
    max_d     = max_q;
    clr_cnt_d = clr_cnt_q;
    limit_d   = limit_q;
    run_d     = run_q;
    loop_d    = loop_q;
    b32_d     = b32_q;
    disp_d    = disp_q;
    wr_d      = wr_q;
    swp_d     = swp_q;

    if (reg_wr && reg_idx == 3'd0) max_d[7:0]  = busDataIn;
    if (reg_wr && reg_idx == 3'd1) max_d[12:8] = busDataIn[4:0];

    if (init_start)                   clr_cnt_d = '0;
    else if (init_busy && !clear_last) clr_cnt_d = clr_cnt_q + 1'b1;

    if (!init_busy) begin
      if (reg_wr && reg_idx == 3'd2) begin
        {b32_d, loop_d, run_d, limit_d} = busDataIn[4:1];
      end else if (syncStart) begin
        run_d = 1'b1;
      end else if (stream_sync_of) begin
        run_d = loop_q;
      end
      if (reg_wr && reg_idx == 3'd4 && bank_req != disp_q) wr_d = bank_req;
      if (swap_apply) begin
        disp_d = wr_q;
        wr_d   = wr_inc;
        swp_d  = 1'b0;
      end
      // A request landing on the apply edge survives for the next frame.
      if (reg_wr && reg_idx == 3'd5 && busDataIn[0]) swp_d = 1'b1;
    end

    if (init_start) begin
      {b32_d, loop_d, run_d, limit_d} = 4'b0;
      swp_d = 1'b0;
    end
    if (clear_last) begin
      disp_d = '0;
      wr_d   = BANK_ONE;
      max_d  = MAX_RST;
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (busRead) begin
      if (is_reg) begin
        case (reg_idx)
          3'd0:    dout_d = max_q[7:0];
          3'd1:    dout_d = {3'b0, max_q[12:8]};
          3'd2:    dout_d = {3'b0, b32_q, loop_q, run_q, limit_q, init_busy};
          3'd3:    dout_d = {5'b0, swp_q, init_busy, state};
          3'd4:    dout_d = 8'(wr_q);
          3'd5:    dout_d = {7'b0, swp_q};
          3'd6:    dout_d = 8'(disp_q);
          default: dout_d = 8'(BANKS - 1);
        endcase
      end else if (init_busy || !buf_ok) begin
        dout_d = 8'h00;
      end else begin
        dout_d = mem_q[wr_q][buf_idx];
      end
    end
    ddata_d = didx_ok ? mem_q[disp_q][displayIndex] : 8'h00;
  end

  always_ff @(posedge busClk or negedge busResetN) begin
    if (!busResetN) begin
      clr_cnt_q <= '0;
      max_q     <= MAX_RST;
      limit_q   <= 1'b0;
      run_q     <= 1'b0;
      loop_q    <= 1'b0;
      b32_q     <= 1'b0;
      disp_q    <= '0;
      wr_q      <= BANK_ONE;
      swp_q     <= 1'b0;
      dout_q    <= 8'h00;
      ddata_q   <= 8'h00;
    end else begin
      clr_cnt_q <= clr_cnt_d;
      max_q     <= max_d;
      limit_q   <= limit_d;
      run_q     <= run_d;
      loop_q    <= loop_d;
      b32_q     <= b32_d;
      disp_q    <= disp_d;
      wr_q      <= wr_d;
      swp_q     <= swp_d;
      dout_q    <= dout_d;
      ddata_q   <= ddata_d;
    end
  end

  // Pixel storage is deliberately unreset; the clear sequencer owns initialisation.
  always_ff @(posedge busClk) begin
    for (int b = 0; b < BANKS; b++) begin
      if (init_busy) mem_q[b][clr_cnt_q] <= 8'h00;
    end
    if (buf_we) mem_q[wr_q][buf_idx] <= busDataIn;
  end

  assign busDataOut     = dout_q;
  assign displayData    = ddata_q;
  assign reg_max        = max_q;
  assign reg_ctrl_limit = limit_q;
  assign reg_ctrl_run   = run_q;
  assign reg_ctrl_loop  = loop_q;
  assign reg_ctrl_32bit = b32_q;
  assign displayBank    = disp_q;
  assign writeBank      = wr_q;
  assign initBusy       = init_busy;
  assign swapPending    = swp_q;
endmodule

// File: tb/tb_anton_neopixel_registers_banked.sv
// Directed plus randomized bench for the banked NeoPixel register file, BANKS=3, BUFFER_END=15.
module tb_anton_neopixel_registers_banked;
  localparam int BE = 15;
  localparam int NB = 3;
  localparam logic [13:0] REG = 14'h2000;

  logic        busClk = 1'b0;
  logic        busResetN;
  logic [13:0] busAddr;
  logic [7:0]  busDataIn;
  logic        busWrite, busRead, stream_sync_of, syncStart, state;
  logic [3:0]  displayIndex;
  logic [7:0]  busDataOut, displayData;
  logic [12:0] reg_max;
  logic        reg_ctrl_limit, reg_ctrl_run, reg_ctrl_loop, reg_ctrl_32bit;
  logic [1:0]  displayBank, writeBank;
  logic        initBusy, swapPending;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int         m_max, m_limit, m_run, m_loop, m_b32, m_disp, m_wr, m_swp, m_busy, m_cnt;
  logic [7:0] m_dout, m_ddata;
  logic [7:0] m_mem [NB][BE+1];

  anton_neopixel_registers_banked #(.BUFFER_END(BE), .BANKS(NB), .ADDR_BITS(14)) dut (
    .busClk(busClk), .busResetN(busResetN), .busAddr(busAddr), .busDataIn(busDataIn),
    .busWrite(busWrite), .busRead(busRead), .busDataOut(busDataOut),
    .stream_sync_of(stream_sync_of), .syncStart(syncStart), .state(state),
    .displayIndex(displayIndex), .displayData(displayData), .reg_max(reg_max),
    .reg_ctrl_limit(reg_ctrl_limit), .reg_ctrl_run(reg_ctrl_run),
    .reg_ctrl_loop(reg_ctrl_loop), .reg_ctrl_32bit(reg_ctrl_32bit),
    .displayBank(displayBank), .writeBank(writeBank), .initBusy(initBusy),
    .swapPending(swapPending)
  );

  always #5 busClk = ~busClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] reg_val(input int i);
    case (i)
      0: return 8'(m_max & 'hFF);
      1: return 8'((m_max >> 8) & 'h1F);
      2: return 8'((m_b32 << 4) | (m_loop << 3) | (m_run << 2) | (m_limit << 1) | m_busy);
      3: return 8'((m_swp << 2) | (m_busy << 1) | int'(state));
      4: return 8'(m_wr);
      5: return 8'(m_swp);
      6: return 8'(m_disp);
      default: return 8'(NB - 1);
    endcase
  endfunction

  task automatic model_reset();
    m_max = BE; m_limit = 0; m_run = 0; m_loop = 0; m_b32 = 0;
    m_disp = 0; m_wr = 1; m_swp = 0; m_busy = 0; m_cnt = 0;
    m_dout = 8'h00; m_ddata = 8'h00;
  endtask

  // Apply one clock of the specified behaviour to the model, then clock the DUT.
  task automatic cyc();
    bit         isreg, start, apply, wr2;
    int         idx, ba, o_wr, o_run, o_loop, o_swp, v;
    logic [7:0] d;
    isreg = busAddr[13];
    idx = int'(busAddr[2:0]);
    ba  = int'(busAddr[12:0]);
    d   = busDataIn;
    o_wr = m_wr; o_run = m_run; o_loop = m_loop; o_swp = m_swp;
    if (busRead)
      m_dout = isreg ? reg_val(idx) : ((m_busy != 0 || ba > BE) ? 8'h00 : m_mem[o_wr][ba]);
    m_ddata = (int'(displayIndex) > BE) ? 8'h00 : m_mem[m_disp][displayIndex];
    if (busWrite && isreg && idx == 0) m_max = (m_max & 'h1F00) | int'(d);
    if (busWrite && isreg && idx == 1) m_max = (m_max & 'hFF) | ((int'(d) & 'h1F) << 8);
    if (m_busy != 0) begin
      for (int b = 0; b < NB; b++) m_mem[b][m_cnt] = 8'h00;
      if (m_cnt == BE) begin
        m_busy = 0; m_disp = 0; m_wr = 1; m_max = BE;
      end else m_cnt++;
    end else begin
      wr2   = busWrite && isreg && idx == 2;
      start = wr2 && d[0];
      apply = (o_swp != 0) && (stream_sync_of || o_run == 0) && !start;
      if (busWrite && !isreg && ba <= BE) m_mem[o_wr][ba] = d;
      if (wr2) begin
        m_limit = int'(d[1]); m_run = int'(d[2]); m_loop = int'(d[3]); m_b32 = int'(d[4]);
      end else if (syncStart) m_run = 1;
      else if (stream_sync_of) m_run = o_loop;
      v = int'(d) % NB;
      if (busWrite && isreg && idx == 4 && v != m_disp) m_wr = v;
      if (apply) begin
        m_disp = o_wr; m_wr = (o_wr + 1) % NB; m_swp = 0;
      end
      if (busWrite && isreg && idx == 5 && d[0]) m_swp = 1;
      if (start) begin
        m_busy = 1; m_cnt = 0; m_limit = 0; m_run = 0; m_loop = 0; m_b32 = 0; m_swp = 0;
      end
    end
    @(posedge busClk);
    #1;
    busWrite = 0; busRead = 0; stream_sync_of = 0; syncStart = 0;
  endtask

  task automatic check_all();
    chk("dout", busDataOut, m_dout);
    chk("ddata", displayData, m_ddata);
    chk("disp_bank", displayBank, m_disp);
    chk("write_bank", writeBank, m_wr);
    chk("swap_pending", swapPending, m_swp);
    chk("init_busy", initBusy, m_busy);
    chk("reg_max", reg_max, m_max);
    chk("run", reg_ctrl_run, m_run);
    chk("loop", reg_ctrl_loop, m_loop);
    chk("limit", reg_ctrl_limit, m_limit);
    chk("b32", reg_ctrl_32bit, m_b32);
  endtask

  task automatic bus_wr(input logic [13:0] a, input logic [7:0] d);
    busAddr = a; busDataIn = d; busWrite = 1;
    cyc(); check_all();
  endtask

  task automatic bus_rd(input logic [13:0] a);
    busAddr = a; busRead = 1;
    cyc(); check_all();
  endtask

  task automatic fill_ff();
    for (int i = 0; i <= BE; i++) bus_wr(14'(i), 8'hFF);
  endtask

  task automatic run_init(input string tag);
    int n;
    bus_wr(REG | 14'd2, 8'h01);
    n = 0;
    for (int k = 0; k < 40 && initBusy; k++) begin
      busAddr = 14'd3; busRead = 1;
      cyc(); check_all();
      n++;
      if (n == 1) chk({tag, "_rd_clear"}, busDataOut, 0);
    end
    chk({tag, "_len"}, n, BE + 1);
  endtask

  initial begin
    int exp_regs[8];
    exp_regs = '{BE, 0, 0, 0, 1, 0, 0, NB - 1};
    busResetN = 0; busAddr = '0; busDataIn = '0; busWrite = 0; busRead = 0;
    stream_sync_of = 0; syncStart = 0; state = 0; displayIndex = '0;
    model_reset();
    #12;
    check_all();
    @(negedge busClk);
    busResetN = 1;

    for (int i = 0; i < 8; i++) begin
      bus_rd(REG | 14'(i));
      chk("reset_reg", busDataOut, exp_regs[i]);
    end

    bus_wr(14'd3, 8'hA5);
    bus_rd(14'd3);
    chk("buf_rd", busDataOut, 8'hA5);
    bus_wr(14'(BE + 1), 8'h77);
    bus_rd(14'(BE + 1));
    chk("buf_oob", busDataOut, 0);

    // Swap is held while running until the frame boundary.
    bus_wr(REG | 14'd2, 8'h04);
    bus_wr(REG | 14'd5, 8'h01);
    repeat (50) begin cyc(); check_all(); end
    chk("swap_held", swapPending, 1);
    chk("swap_held_disp", displayBank, 0);
    stream_sync_of = 1;
    cyc(); check_all();
    chk("swap_disp", displayBank, 1);
    chk("swap_wr", writeBank, 2);
    chk("swap_clr", swapPending, 0);
    displayIndex = 4'd3;
    cyc(); check_all();
    chk("swap_ddata", displayData, 8'hA5);

    bus_wr(REG | 14'd2, 8'h04);
    syncStart = 1; stream_sync_of = 1;
    cyc(); check_all();
    chk("run_prio", reg_ctrl_run, 1);
    stream_sync_of = 1;
    cyc(); check_all();
    chk("run_noloop", reg_ctrl_run, 0);

    // Fill every bank with 0xFF, steering the bus to each in turn.
    fill_ff();
    bus_wr(REG | 14'd4, 8'h00);
    fill_ff();
    bus_wr(REG | 14'd5, 8'h01);
    cyc(); check_all();
    chk("idle_swap_disp", displayBank, 0);
    fill_ff();
    run_init("init");
    chk("init_disp", displayBank, 0);
    chk("init_wr", writeBank, 1);
    for (int i = 0; i <= BE; i++) begin bus_rd(14'(i)); chk("zero_bank1", busDataOut, 0); end
    for (int i = 0; i <= BE; i++) begin
      displayIndex = 4'(i);
      cyc(); check_all();
      chk("zero_bank0", displayData, 0);
    end
    bus_wr(REG | 14'd4, 8'h02);
    for (int i = 0; i <= BE; i++) begin bus_rd(14'(i)); chk("zero_bank2", busDataOut, 0); end

    // Reset in the middle of a clear aborts immediately.
    bus_wr(REG | 14'd2, 8'h01);
    repeat (5) begin cyc(); check_all(); end
    #2 busResetN = 0;
    #1 chk("rst_abort_busy", initBusy, 0);
    chk("rst_abort_wr", writeBank, 1);
    model_reset();
    check_all();
    @(negedge busClk);
    busResetN = 1;
    run_init("reinit");

    for (int n = 0; n < 500; n++) begin
      int r;
      logic [13:0] a;
      logic [7:0] d;
      r = $urandom_range(0, 9);
      a = 14'($urandom_range(0, 20));
      d = 8'($urandom_range(0, 255));
      displayIndex = 4'($urandom_range(0, BE));
      state = 1'($urandom_range(0, 1));
      case (r)
        0, 1: begin busAddr = a; busDataIn = d; busWrite = 1; busRead = 1'($urandom_range(0, 1)); end
        2, 3: begin busAddr = a; busRead = 1; end
        4: begin busAddr = REG | 14'($urandom_range(0, 7)); busRead = 1; end
        5: begin busAddr = REG | 14'($urandom_range(0, 1)); busDataIn = d; busWrite = 1; end
        6: begin
          busAddr = REG | 14'd2; busWrite = 1;
          busDataIn = ($urandom_range(0, 39) == 0) ? 8'h01 : (d & 8'h1E);
        end
        7: begin busAddr = REG | 14'd4; busDataIn = d; busWrite = 1; end
        8: begin busAddr = REG | 14'd5; busDataIn = d; busWrite = 1; end
        default: ;
      endcase
      stream_sync_of = ($urandom_range(0, 7) == 0);
      syncStart = ($urandom_range(0, 9) == 0);
      cyc(); check_all();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
